// File: rtl/switch_debounce.sv
// ---------------------------------------------------------------------------
// switch_debounce
//
// Debounces a group of mechanical switch inputs (slide switches or a DIP
// bank). Each bit is brought into the sys_clk_in domain through two flops.
// A change is accepted only after the synchronized level has differed from
// the debounced level for DEBOUNCE_CYCLES consecutive cycles. Accepted
// changes produce one-cycle edge strobes, bump an 8-bit change counter and
// set a sticky event flag that software clears with event_ack.
//
// Ports
//   sys_clk_in     in   1      system clock, rising-edge active
//   sys_rst_n      in   1      asynchronous active-low reset
//   raw_in         in   WIDTH  asynchronous switch levels from the pins
//   clean_out      out  WIDTH  debounced levels
//   rise_pulse     out  WIDTH  one-cycle strobe per bit on accepted 0->1
//   fall_pulse     out  WIDTH  one-cycle strobe per bit on accepted 1->0
//   change_pulse   out  1      OR of all rise/fall strobes
//   change_cnt     out  8      number of cycles with change_pulse high (wraps)
//   event_pending  out  1      sticky flag, set by any accepted change
//   event_ack      in   1      synchronous clear request for event_pending
//
// Parameters
//   WIDTH            number of switch bits (default 5)
//   DEBOUNCE_CYCLES  stable cycles required to accept a change, 1..2^24-1
//                    (default 1000000 = 10 ms at 100 MHz)
// ---------------------------------------------------------------------------
module switch_debounce #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             sys_clk_in,
    input  logic             sys_rst_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             change_pulse,
    output logic [7:0]       change_cnt,
    output logic             event_pending,
    input  logic             event_ack
);

    // Terminal count of the per-bit stability counter. The counter sits at
    // TC on the edge where the change is accepted, so a held difference is
    // accepted after exactly DEBOUNCE_CYCLES cycles of disagreement.
    localparam logic [23:0] TC = 24'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_clean;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_change;
    logic [7:0]       r_change_cnt;
    logic             r_event_pending;

    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_accept;

    // -----------------------------------------------------------------------
    // Two-flop synchronizer; the only logic that touches raw_in.
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_diff = r_sync2 ^ r_clean;

    // -----------------------------------------------------------------------
    // Per-bit stability counters. A bit that agrees with its debounced level
    // holds its counter at zero, so any glitch that returns before
    // acceptance throws the partial count away and a later difference
    // starts again from zero.
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        logic [23:0] r_stab;

        assign w_accept[g] = w_diff[g] && (r_stab == TC);

        always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_stab <= '0;
            end else if (!w_diff[g] || w_accept[g]) begin
                r_stab <= '0;
            end else begin
                r_stab <= r_stab + 24'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Debounced level and edge strobes. The strobes are registered on the
    // same edge that updates r_clean, so they line up with the first cycle
    // in which clean_out shows the new value.
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_clean  <= '0;
            r_rise   <= '0;
            r_fall   <= '0;
            r_change <= 1'b0;
        end else begin
            r_clean  <= r_clean ^ w_accept;
            r_rise   <= w_accept & r_sync2;
            r_fall   <= w_accept & ~r_sync2;
            r_change <= |w_accept;
        end
    end

    // -----------------------------------------------------------------------
    // Change counter and sticky event flag, both driven by the registered
    // change strobe. A change in the same cycle as an acknowledge keeps the
    // flag set so that no event is lost.
    // -----------------------------------------------------------------------
    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_change_cnt    <= '0;
            r_event_pending <= 1'b0;
        end else begin
            if (r_change) begin
                r_change_cnt <= r_change_cnt + 8'd1;
            end
            r_event_pending <= r_change | (r_event_pending & ~event_ack);
        end
    end

    assign clean_out     = r_clean;
    assign rise_pulse    = r_rise;
    assign fall_pulse    = r_fall;
    assign change_pulse  = r_change;
    assign change_cnt    = r_change_cnt;
    assign event_pending = r_event_pending;

endmodule

// File: tb/tb_switch_debounce.sv
module tb_switch_debounce;

    localparam int WIDTH = 5;
    localparam int DEB   = 4;

    logic             sys_clk_in;
    logic             sys_rst_n;
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] clean_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;
    logic             change_pulse;
    logic [7:0]       change_cnt;
    logic             event_pending;
    logic             event_ack;

    int n_vec;
    int n_err;

    switch_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .sys_clk_in    (sys_clk_in),
        .sys_rst_n     (sys_rst_n),
        .raw_in        (raw_in),
        .clean_out     (clean_out),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse),
        .change_pulse  (change_pulse),
        .change_cnt    (change_cnt),
        .event_pending (event_pending),
        .event_ack     (event_ack)
    );

    initial begin
        sys_clk_in = 1'b0;
        forever #5 sys_clk_in = ~sys_clk_in;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // advance one rising edge, then settle before sampling or driving
    task automatic tick();
        @(posedge sys_clk_in);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " clean"},  32'(clean_out),     32'h0);
        chk({tag, " rise"},   32'(rise_pulse),    32'h0);
        chk({tag, " fall"},   32'(fall_pulse),    32'h0);
        chk({tag, " change"}, 32'(change_pulse),  32'h0);
        chk({tag, " cnt"},    32'(change_cnt),    32'h0);
        chk({tag, " pend"},   32'(event_pending), 32'h0);
    endtask

    int rises;
    int falls;
    int bad;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        raw_in    = '0;
        event_ack = 1'b0;
        sys_rst_n = 1'b0;

        // reset values present before any clock edge
        #1;
        chk_all_zero("rst0");
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
        tick();
        chk("idle clean", 32'(clean_out), 32'h0);

        // single bit 0->1, accepted on edge DEB+2 = 6
        raw_in = 5'b00001;
        for (int e = 1; e <= DEB + 1; e++) begin
            tick();
            chk("s1 early clean", 32'(clean_out), 32'h0);
            chk("s1 early rise", 32'(rise_pulse), 32'h0);
        end
        tick();
        chk("s1 clean", 32'(clean_out), 32'h01);
        chk("s1 rise", 32'(rise_pulse), 32'h01);
        chk("s1 fall", 32'(fall_pulse), 32'h0);
        chk("s1 change", 32'(change_pulse), 32'h1);
        chk("s1 cnt pre", 32'(change_cnt), 32'h0);
        tick();
        chk("s1 rise gone", 32'(rise_pulse), 32'h0);
        chk("s1 change gone", 32'(change_pulse), 32'h0);
        chk("s1 cnt", 32'(change_cnt), 32'h1);
        chk("s1 pend", 32'(event_pending), 32'h1);
        chk("s1 clean hold", 32'(clean_out), 32'h01);

        // bit 2 glitch of 3 cycles: one short of acceptance
        raw_in = 5'b00101;
        tick();
        tick();
        tick();
        raw_in = 5'b00001;
        for (int e = 0; e < 10; e++) begin
            tick();
            chk("glitch clean", 32'(clean_out), 32'h01);
            chk("glitch pulses", 32'({rise_pulse, fall_pulse}), 32'h0);
        end
        chk("glitch cnt", 32'(change_cnt), 32'h1);

        // later difference restarts from zero: full latency again
        raw_in = 5'b00101;
        for (int e = 1; e <= DEB + 1; e++) begin
            tick();
            chk("restart early clean", 32'(clean_out), 32'h01);
        end
        tick();
        chk("restart clean", 32'(clean_out), 32'h05);
        chk("restart rise", 32'(rise_pulse), 32'h04);
        tick();
        chk("restart cnt", 32'(change_cnt), 32'h2);

        // two bits falling together
        raw_in = 5'b00000;
        for (int e = 1; e <= DEB + 1; e++) tick();
        chk("fall2 early clean", 32'(clean_out), 32'h05);
        tick();
        chk("fall2 clean", 32'(clean_out), 32'h0);
        chk("fall2 fall", 32'(fall_pulse), 32'h05);
        chk("fall2 rise", 32'(rise_pulse), 32'h0);
        tick();
        chk("fall2 cnt", 32'(change_cnt), 32'h3);

        // acknowledge clears the flag; acknowledge with flag clear is a no-op
        event_ack = 1'b1;
        tick();
        event_ack = 1'b0;
        chk("ack clear", 32'(event_pending), 32'h0);
        event_ack = 1'b1;
        tick();
        event_ack = 1'b0;
        chk("ack idle", 32'(event_pending), 32'h0);
        chk("ack idle cnt", 32'(change_cnt), 32'h3);

        // two bits rising on one edge, with ack coinciding with change_pulse
        raw_in = 5'b10010;
        for (int e = 1; e <= DEB + 1; e++) tick();
        chk("multi early clean", 32'(clean_out), 32'h0);
        tick();
        chk("multi clean", 32'(clean_out), 32'h12);
        chk("multi rise", 32'(rise_pulse), 32'h12);
        chk("multi change", 32'(change_pulse), 32'h1);
        event_ack = 1'b1;
        tick();
        chk("ack+change pend", 32'(event_pending), 32'h1);
        chk("multi cnt", 32'(change_cnt), 32'h4);
        tick();
        event_ack = 1'b0;
        chk("ack alone pend", 32'(event_pending), 32'h0);

        // 256 accepted toggles of bit 0: counter wraps back to its start
        rises = 0;
        falls = 0;
        bad   = 0;
        for (int t = 0; t < 256; t++) begin
            raw_in[0] = ~raw_in[0];
            for (int k = 1; k <= DEB + 2; k++) begin
                tick();
                if (rise_pulse[0]) rises++;
                if (fall_pulse[0]) falls++;
                if ((rise_pulse[4:1] | fall_pulse[4:1]) != 4'b0) bad++;
                if (k != DEB + 2 && (rise_pulse[0] | fall_pulse[0])) bad++;
                if (k == DEB + 2 && !(rise_pulse[0] ^ fall_pulse[0])) bad++;
            end
        end
        tick();
        chk("wrap cnt", 32'(change_cnt), 32'h4);
        chk("wrap rises", 32'(rises), 32'd128);
        chk("wrap falls", 32'(falls), 32'd128);
        chk("wrap timing", 32'(bad), 32'd0);
        chk("wrap clean", 32'(clean_out), 32'h12);
        chk("wrap pend", 32'(event_pending), 32'h1);

        // reset mid-count discards partial counts and clears everything
        raw_in = 5'b11111;
        for (int e = 0; e < 4; e++) tick();
        sys_rst_n = 1'b0;
        #1;
        chk_all_zero("rst mid");
        tick();
        tick();
        chk_all_zero("rst held");
        sys_rst_n = 1'b1;
        for (int e = 1; e <= DEB + 1; e++) begin
            tick();
            chk("post-rst early clean", 32'(clean_out), 32'h0);
            chk("post-rst early rise", 32'(rise_pulse), 32'h0);
        end
        tick();
        chk("post-rst clean", 32'(clean_out), 32'h1f);
        chk("post-rst rise", 32'(rise_pulse), 32'h1f);
        chk("post-rst fall", 32'(fall_pulse), 32'h0);
        tick();
        chk("post-rst cnt", 32'(change_cnt), 32'h1);
        chk("post-rst pend", 32'(event_pending), 32'h1);
        chk("post-rst rise gone", 32'(rise_pulse), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
